// File: rtl/key_debounce_encoder_if.sv
// Key bus between the raw organ buttons and the player: raw keys in, clean levels and note events out.
interface key_debounce_encoder_if;
    logic [13:0] key_raw;
    logic [13:0] key_clean;
    logic [3:0]  note_code;
    logic        note_valid;
    logic        note_press;
    logic        note_release;

    modport master (
        output key_raw,
        input  key_clean, note_code, note_valid, note_press, note_release
    );

    modport slave (
        input  key_raw,
        output key_clean, note_code, note_valid, note_press, note_release
    );
endinterface

// File: rtl/key_debounce_encoder.sv
// Synchronizes, debounces and priority-encodes the 14 organ keys into a registered note code.
// Optional KEY_HOLD_LAST_EN: note_code keeps the last nonzero note after all keys release.
module key_debounce_encoder #(
    parameter int CLK_HZ     = 50000000,
    parameter int SAMPLE_HZ  = 1000,
    parameter int STABLE_CNT = 20,
    parameter int ACTIVE_LOW = 1
) (
    input logic                    clk_in,
    input logic                    rst,
    key_debounce_encoder_if.slave  kbus
);
    localparam int DIV   = CLK_HZ / SAMPLE_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CNT_W = $clog2(STABLE_CNT) + 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);
    // Raw level of a released key; also the XOR mask that makes pressed = 1.
    localparam logic [13:0] POL = (ACTIVE_LOW != 0) ? 14'h3FFF : 14'h0000;

    logic [13:0]      sync_p0;
    logic [13:0]      sync_p1;
    logic [13:0]      sample;
    logic [DIV_W-1:0] tick_cnt;
    logic             tick;
    logic [CNT_W-1:0] cnt [14];
    logic [13:0]      clean;
    logic [3:0]       enc_code;
    logic             enc_vld;
    logic [3:0]       next_code;
    logic             next_press;
    logic             next_release;
    logic [3:0]       code_p0;
    logic             vld_p0;
    logic             press_p0;
    logic             release_p0;

    // Stage p0/p1: two-flop synchronizer on the raw pins
    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync_p0 <= POL;
            sync_p1 <= POL;
        end else begin
            sync_p0 <= kbus.key_raw;
            sync_p1 <= sync_p0;
        end
    end

    assign sample = sync_p1 ^ POL;
    assign tick   = (tick_cnt == DIV_MAX);

    // Debounce: sampled once per tick, a key flips after STABLE_CNT consecutive differing samples
    always_ff @(posedge clk_in) begin
        if (rst) begin
            tick_cnt <= '0;
            clean    <= '0;
            for (int i = 0; i < 14; i++) cnt[i] <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
                for (int i = 0; i < 14; i++) begin
                    if (sample[i] == clean[i]) begin
                        cnt[i] <= '0;
                    end else if (cnt[i] == CNT_MAX) begin
                        clean[i] <= ~clean[i];
                        cnt[i]   <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        enc_code = 4'd0;
        for (int i = 13; i >= 0; i--) begin
            if (clean[i]) enc_code = 4'(i + 1);
        end
    end

    always_comb begin
        enc_vld = (enc_code != 4'd0);
`ifdef KEY_HOLD_LAST_EN
        next_code  = enc_vld ? enc_code : code_p0;
        // Re-pressing the held note leaves the code unchanged, so the valid edge flags it
        next_press = enc_vld && ((next_code != code_p0) || !vld_p0);
`else
        next_code  = enc_code;
        next_press = enc_vld && (next_code != code_p0);
`endif
        next_release = vld_p0 && !enc_vld;
    end

    // Output stage: note code, valid and strobes registered together
    always_ff @(posedge clk_in) begin
        if (rst) begin
            code_p0    <= 4'd0;
            vld_p0     <= 1'b0;
            press_p0   <= 1'b0;
            release_p0 <= 1'b0;
        end else begin
            code_p0    <= next_code;
            vld_p0     <= enc_vld;
            press_p0   <= next_press;
            release_p0 <= next_release;
        end
    end

    assign kbus.key_clean    = clean;
    assign kbus.note_code    = code_p0;
    assign kbus.note_valid   = vld_p0;
    assign kbus.note_press   = press_p0;
    assign kbus.note_release = release_p0;
endmodule

// File: tb/tb_key_debounce_encoder.sv
// Directed bench for key_debounce_encoder with a 10-cycle tick and 4-tick debounce.
module tb_key_debounce_encoder;
    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   press_cnt    = 0;
    int   rel_cnt      = 0;
    int   both_cnt     = 0;

    key_debounce_encoder_if kbus ();

    key_debounce_encoder #(
        .CLK_HZ(1000), .SAMPLE_HZ(100), .STABLE_CNT(4), .ACTIVE_LOW(1)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .kbus   (kbus)
    );

    always #5 clk_in = ~clk_in;

    // Strobe tally on the falling edge, midway between updates
    always @(negedge clk_in) begin
        if (kbus.note_press === 1'b1)   press_cnt++;
        if (kbus.note_release === 1'b1) rel_cnt++;
        if (kbus.note_press === 1'b1 && kbus.note_release === 1'b1) both_cnt++;
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_code(input logic [3:0] code, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 60 && !ok; n++) begin
            step();
            if (kbus.note_code == code && kbus.note_valid) ok = 1'b1;
        end
    endtask

    task automatic wait_invalid(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 60 && !ok; n++) begin
            step();
            if (!kbus.note_valid) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        bit quiet = 1'b1;
        kbus.key_raw = 14'h3FFF;
        rst = 1'b1;
        repeat (3) step();
        tests_run++;
        if (kbus.key_clean !== 14'h0 || kbus.note_code !== 4'd0 || kbus.note_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: clean=%h code=%0d valid=%b, want 0/0/0", kbus.key_clean, kbus.note_code, kbus.note_valid);
        end
        tests_run++;
        if (kbus.note_press !== 1'b0 || kbus.note_release !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_strobes: press=%b release=%b, want 0/0", kbus.note_press, kbus.note_release);
        end
        rst = 1'b0;
        for (int c = 0; c < 100; c++) begin
            step();
            if (kbus.key_clean != 14'h0 || kbus.note_code != 4'd0 || kbus.note_valid) quiet = 1'b0;
        end
        tests_run++;
        if (!quiet || press_cnt != 0 || rel_cnt != 0) begin
            tests_failed++;
            $display("FAIL reset_idle: quiet=%b press=%0d release=%0d, want 1/0/0", quiet, press_cnt, rel_cnt);
        end
    endtask

    task automatic test_clean_press();
        int  n = 0;
        bit  hit = 1'b0;
        bit  ok;
        int  pc = press_cnt;
        int  rc;
        kbus.key_raw[4] = 1'b0;
        while (!hit && n < 60) begin
            step();
            n++;
            if (kbus.key_clean[4]) hit = 1'b1;
        end
        tests_run++;
        if (!hit || n < 33 || n > 42) begin
            tests_failed++;
            $display("FAIL press_latency: %0d cycles (seen=%b), want 33..42", n, hit);
        end
        tests_run++;
        if (kbus.key_clean !== 14'h0010 || kbus.note_code !== 4'd0) begin
            tests_failed++;
            $display("FAIL press_clean: clean=%h code=%0d, want 0010/0", kbus.key_clean, kbus.note_code);
        end
        step();
        tests_run++;
        if (kbus.note_code !== 4'd5 || kbus.note_valid !== 1'b1 || kbus.note_press !== 1'b1) begin
            tests_failed++;
            $display("FAIL press_code: code=%0d valid=%b press=%b, want 5/1/1", kbus.note_code, kbus.note_valid, kbus.note_press);
        end
        step();
        tests_run++;
        if (kbus.note_press !== 1'b0) begin
            tests_failed++;
            $display("FAIL press_width: press=%b second cycle, want 0", kbus.note_press);
        end
        repeat (40) step();
        tests_run++;
        if (press_cnt - pc != 1) begin
            tests_failed++;
            $display("FAIL press_count: %0d presses, want 1", press_cnt - pc);
        end
        rc = rel_cnt;
        kbus.key_raw[4] = 1'b1;
        wait_invalid(ok);
        repeat (3) step();
        tests_run++;
        if (!ok || rel_cnt - rc != 1) begin
            tests_failed++;
            $display("FAIL press_release: seen=%b releases=%0d, want 1/1", ok, rel_cnt - rc);
        end
    endtask

    task automatic test_bounce();
        bit stayed = 1'b1;
        int pc = press_cnt;
        int rc = rel_cnt;
        for (int c = 0; c < 200; c++) begin
            if (c % 15 == 0) kbus.key_raw[2] = ~kbus.key_raw[2];
            step();
            if (kbus.key_clean != 14'h0) stayed = 1'b0;
        end
        kbus.key_raw[2] = 1'b1;
        repeat (30) step();
        tests_run++;
        if (!stayed || press_cnt != pc || rel_cnt != rc) begin
            tests_failed++;
            $display("FAIL bounce: clean_stayed=%b press=%0d release=%0d, want 1/0/0", stayed, press_cnt - pc, rel_cnt - rc);
        end
    endtask

    task automatic test_priority();
        bit ok;
        int pc = press_cnt;
        int rc = rel_cnt;
        kbus.key_raw[9] = 1'b0;
        wait_code(4'd10, ok);
        repeat (3) step();
        tests_run++;
        if (!ok || press_cnt - pc != 1) begin
            tests_failed++;
            $display("FAIL prio_first: seen=%b presses=%0d code=%0d, want 1/1/10", ok, press_cnt - pc, kbus.note_code);
        end
        pc = press_cnt;
        kbus.key_raw[1] = 1'b0;
        wait_code(4'd2, ok);
        repeat (3) step();
        tests_run++;
        if (!ok || press_cnt - pc != 1 || rel_cnt != rc) begin
            tests_failed++;
            $display("FAIL prio_lower: seen=%b presses=%0d releases=%0d, want 1/1/0", ok, press_cnt - pc, rel_cnt - rc);
        end
        pc = press_cnt;
        kbus.key_raw[1] = 1'b1;
        wait_code(4'd10, ok);
        repeat (3) step();
        tests_run++;
        if (!ok || press_cnt - pc != 1 || rel_cnt != rc) begin
            tests_failed++;
            $display("FAIL prio_back: seen=%b presses=%0d releases=%0d, want 1/1/0", ok, press_cnt - pc, rel_cnt - rc);
        end
        kbus.key_raw[1] = 1'b0;
        wait_code(4'd2, ok);
        repeat (3) step();
        pc = press_cnt;
        kbus.key_raw[9] = 1'b1;
        repeat (60) step();
        tests_run++;
        if (!ok || kbus.note_code !== 4'd2 || kbus.key_clean !== 14'h0002 || press_cnt != pc || rel_cnt != rc) begin
            tests_failed++;
            $display("FAIL prio_nonwinner: code=%0d clean=%h presses=%0d releases=%0d, want 2/0002/0/0", kbus.note_code, kbus.key_clean, press_cnt - pc, rel_cnt - rc);
        end
        kbus.key_raw[1] = 1'b1;
        wait_invalid(ok);
        repeat (3) step();
        tests_run++;
        if (!ok || rel_cnt - rc != 1 || press_cnt != pc) begin
            tests_failed++;
            $display("FAIL prio_release: seen=%b releases=%0d presses=%0d, want 1/1/0", ok, rel_cnt - rc, press_cnt - pc);
        end
`ifdef KEY_HOLD_LAST_EN
        tests_run++;
        if (kbus.note_code !== 4'd2) begin
            tests_failed++;
            $display("FAIL prio_final_code: code=%0d, want 2 held", kbus.note_code);
        end
`else
        tests_run++;
        if (kbus.note_code !== 4'd0) begin
            tests_failed++;
            $display("FAIL prio_final_code: code=%0d, want 0", kbus.note_code);
        end
`endif
    endtask

    task automatic test_simultaneous();
        bit ok;
        int pc = press_cnt;
        int rc = rel_cnt;
        kbus.key_raw[3] = 1'b0;
        kbus.key_raw[7] = 1'b0;
        wait_code(4'd4, ok);
        repeat (20) step();
        tests_run++;
        if (!ok || kbus.key_clean !== 14'h0088 || press_cnt - pc != 1) begin
            tests_failed++;
            $display("FAIL simul_press: seen=%b clean=%h presses=%0d, want 1/0088/1", ok, kbus.key_clean, press_cnt - pc);
        end
        kbus.key_raw[3] = 1'b1;
        kbus.key_raw[7] = 1'b1;
        wait_invalid(ok);
        repeat (20) step();
        tests_run++;
        if (!ok || rel_cnt - rc != 1 || press_cnt - pc != 1) begin
            tests_failed++;
            $display("FAIL simul_release: seen=%b releases=%0d presses=%0d, want 1/1/1", ok, rel_cnt - rc, press_cnt - pc);
        end
        tests_run++;
        if (both_cnt != 0) begin
            tests_failed++;
            $display("FAIL strobe_overlap: %0d cycles with both strobes, want 0", both_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit hit = 1'b0;
        int n = 0;
        int pc = press_cnt;
        kbus.key_raw[6] = 1'b0;
        repeat (25) step();
        rst = 1'b1;
        repeat (3) step();
        tests_run++;
        if (kbus.key_clean !== 14'h0 || kbus.note_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: clean=%h valid=%b, want 0/0", kbus.key_clean, kbus.note_valid);
        end
        rst = 1'b0;
        while (!hit && n < 60) begin
            step();
            n++;
            if (kbus.key_clean[6]) hit = 1'b1;
        end
        tests_run++;
        if (!hit || n != 40) begin
            tests_failed++;
            $display("FAIL midrst_latency: %0d cycles (seen=%b), want 40", n, hit);
        end
        tests_run++;
        if (press_cnt != pc) begin
            tests_failed++;
            $display("FAIL midrst_nostrobe: %0d presses before flip, want 0", press_cnt - pc);
        end
        step();
        tests_run++;
        if (kbus.note_code !== 4'd7 || kbus.note_press !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_code: code=%0d press=%b, want 7/1", kbus.note_code, kbus.note_press);
        end
        kbus.key_raw[6] = 1'b1;
        wait_invalid(ok);
        repeat (3) step();
    endtask

    task automatic test_key13_release();
        bit ok;
        int pc = press_cnt;
        int rc = rel_cnt;
        kbus.key_raw[13] = 1'b0;
        wait_code(4'd14, ok);
        repeat (3) step();
        kbus.key_raw[13] = 1'b1;
        wait_invalid(ok);
        repeat (30) step();
`ifdef KEY_HOLD_LAST_EN
        tests_run++;
        if (!ok || kbus.note_code !== 4'd14 || kbus.note_valid !== 1'b0 || rel_cnt - rc != 1) begin
            tests_failed++;
            $display("FAIL hold_release: code=%0d valid=%b releases=%0d, want 14/0/1", kbus.note_code, kbus.note_valid, rel_cnt - rc);
        end
        kbus.key_raw[13] = 1'b0;
        wait_code(4'd14, ok);
        repeat (3) step();
        tests_run++;
        if (!ok || press_cnt - pc != 2) begin
            tests_failed++;
            $display("FAIL hold_repress: seen=%b presses=%0d, want 1/2", ok, press_cnt - pc);
        end
        kbus.key_raw[13] = 1'b1;
        wait_invalid(ok);
        repeat (3) step();
`else
        tests_run++;
        if (!ok || kbus.note_code !== 4'd0 || kbus.note_valid !== 1'b0 || rel_cnt - rc != 1 || press_cnt - pc != 1) begin
            tests_failed++;
            $display("FAIL key13_release: code=%0d valid=%b releases=%0d presses=%0d, want 0/0/1/1", kbus.note_code, kbus.note_valid, rel_cnt - rc, press_cnt - pc);
        end
`endif
    endtask

    initial begin
        kbus.key_raw = 14'h3FFF;
        test_reset();
        test_clean_press();
        test_bounce();
        test_priority();
        test_simultaneous();
        test_reset_mid();
        test_key13_release();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
